// File: rtl/dec_1.sv
// dec_1: first decoder layer, y = W*x + b over N_OUT parallel signed
// fixed-point MAC lanes, iterating one latent input per cycle.
// Valid/ready handshake on both sides; the result is held until it is taken.
// Optional feature macro: DEC_RELU_EN (ReLU applied after saturation).
module dec_1 #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8,
  parameter int N_IN    = 2,
  parameter int N_OUT   = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BITSIZE*N_IN-1:0]       x,
  input  logic [BITSIZE*N_IN*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BITSIZE*N_OUT-1:0]      y
);

  localparam int ACC_W = 2*BITSIZE + $clog2(N_IN+1);
  localparam int J_W   = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                          r_state;
  logic [J_W-1:0]                  r_j;
  logic [BITSIZE*N_IN-1:0]         r_x;
  logic [BITSIZE*N_IN*N_OUT-1:0]   r_w;
  logic signed [ACC_W-1:0]         r_acc [N_OUT];
  logic [BITSIZE*N_OUT-1:0]        r_y;

  logic                            w_last;
  logic signed [ACC_W-1:0]         w_xe;
  logic signed [ACC_W-1:0]         w_we    [N_OUT];
  logic signed [ACC_W-1:0]         w_prod  [N_OUT];
  logic signed [ACC_W-1:0]         w_acc_nxt [N_OUT];
  logic signed [ACC_W-1:0]         w_shift [N_OUT];
  logic [BITSIZE-1:0]              w_sat   [N_OUT];
  logic [BITSIZE*N_OUT-1:0]        w_y_nxt;

  function automatic logic signed [ACC_W-1:0] sext(input logic [BITSIZE-1:0] v);
    return $signed({{(ACC_W-BITSIZE){v[BITSIZE-1]}}, v});
  endfunction

  // Per-lane MAC step for the current input index, plus shift/saturate/ReLU of the running sum
  always_comb begin
    w_last  = (r_j == J_W'(N_IN-1));
    w_xe    = sext(r_x[BITSIZE*r_j +: BITSIZE]);
    w_y_nxt = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      w_we[i]      = sext(r_w[BITSIZE*N_OUT*r_j + BITSIZE*i +: BITSIZE]);
      w_prod[i]    = w_xe * w_we[i];
      w_acc_nxt[i] = r_acc[i] + w_prod[i];
      w_shift[i]   = w_acc_nxt[i] >>> FRAC;
      if (w_shift[i] > SAT_MAX)
        w_sat[i] = {1'b0, {(BITSIZE-1){1'b1}}};
      else if (w_shift[i] < SAT_MIN)
        w_sat[i] = {1'b1, {(BITSIZE-1){1'b0}}};
      else
        w_sat[i] = w_shift[i][BITSIZE-1:0];
`ifdef DEC_RELU_EN
      if (w_sat[i][BITSIZE-1])
        w_sat[i] = '0;
`else
      w_sat[i] = w_sat[i];
`endif
      w_y_nxt[BITSIZE*i +: BITSIZE] = w_sat[i];
    end
  end

  // Transaction FSM: capture in IDLE, accumulate in MAC, hold result in OUT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_j     <= '0;
      r_x     <= '0;
      r_w     <= '0;
      r_y     <= '0;
      for (int unsigned i = 0; i < N_OUT; i++)
        r_acc[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x <= x;
            r_w <= w;
            // bias lands pre-scaled so the final >>> FRAC treats it as a plain addend
            for (int unsigned i = 0; i < N_OUT; i++)
              r_acc[i] <= sext(b[BITSIZE*i +: BITSIZE]) <<< FRAC;
            r_j     <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          for (int unsigned i = 0; i < N_OUT; i++)
            r_acc[i] <= w_acc_nxt[i];
          if (w_last) begin
            r_y     <= w_y_nxt;
            r_j     <= '0;
            r_state <= OUT;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        OUT: begin
          if (out_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign y         = r_y;

endmodule

// File: tb/tb_dec_1.sv
// Self-checking bench for dec_1: stimulus pushes expected y into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_dec_1;
  localparam int BITSIZE = 16;
  localparam int FRAC    = 8;
  localparam int N_IN    = 2;
  localparam int N_OUT   = 6;

  logic                          clk = 1'b0;
  logic                          reset = 1'b0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [BITSIZE*N_IN-1:0]       x = '0;
  logic [BITSIZE*N_IN*N_OUT-1:0] w = '0;
  logic [BITSIZE*N_OUT-1:0]      b = '0;
  logic                          out_valid;
  logic                          out_ready = 1'b0;
  logic [BITSIZE*N_OUT-1:0]      y;

  int checks = 0;
  int errors = 0;
  logic [BITSIZE*N_OUT-1:0] exp_q[$];

  dec_1 #(.BITSIZE(BITSIZE), .FRAC(FRAC), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef DEC_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [95:0] rep_y(input logic [15:0] v);
    logic [95:0] r;
    for (int i = 0; i < N_OUT; i++) r[16*i +: 16] = relu(v);
    return r;
  endfunction

  function automatic logic [95:0] rep_b(input logic [15:0] v);
    logic [95:0] r;
    for (int i = 0; i < N_OUT; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  function automatic logic [191:0] fill_w(input logic [15:0] w0, input logic [15:0] w1);
    logic [191:0] r;
    for (int i = 0; i < N_OUT; i++) begin
      r[16*i +: 16]            = w0;
      r[16*N_OUT + 16*i +: 16] = w1;
    end
    return r;
  endfunction

  // Monitor: every output handshake must match the oldest expected result
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: actual y %0h with no transaction pending", y);
        end else begin
          e = exp_q.pop_front();
          check("y_result", y, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] xv, input logic [191:0] wv, input logic [95:0] bv,
                      input logic [95:0] ev, input bit drop, output time t_acc);
    int n;
    @(posedge clk); #1;
    x = xv; w = wv; b = bv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual in_ready %0b required 1", in_ready);
      in_valid = 1'b0;
      t_acc = $time;
    end else begin
      exp_q.push_back(ev);
      @(posedge clk);
      t_acc = $time;
      #1;
      if (drop) in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: actual pending %0d required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    time t0, t1, t2;
    int n;
    logic [191:0] wl;
    logic [95:0]  bl, el;

    // reset state
    #2;
    check("rst_out_valid", {95'd0, out_valid}, 96'd0);
    check("rst_y", y, 96'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {95'd0, in_ready}, 96'd1);

    out_ready = 1'b1;

    // basic + latency
    send({16'h0200, 16'h0100}, fill_w(16'h0080, 16'h0100), rep_b(16'h0040), rep_y(16'h02C0), 1'b1, t0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 20);
    check("latency", 96'(n), 96'd2);
    wait_done();

    // saturation high / low
    send({16'h7FFF, 16'h7FFF}, fill_w(16'h7FFF, 16'h7FFF), rep_b(16'h7FFF), rep_y(16'h7FFF), 1'b1, t0);
    wait_done();
    send({16'h7FFF, 16'h7FFF}, fill_w(16'h8000, 16'h8000), rep_b(16'h8000), rep_y(16'h8000), 1'b1, t0);
    wait_done();

    // negative bias, and truncation toward -inf
    send(32'h0, fill_w(16'h0100, 16'h0100), rep_b(16'hFF00), rep_y(16'hFF00), 1'b1, t0);
    wait_done();
    send({16'h0000, 16'hFFFF}, fill_w(16'h0080, 16'h0000), rep_b(16'h0000), rep_y(16'hFFFF), 1'b1, t0);
    wait_done();

    // backpressure with lane-distinct weights/bias
    for (int i = 0; i < N_OUT; i++) begin
      wl[16*i +: 16]            = 16'(16'h0100 * (i + 1));
      wl[16*N_OUT + 16*i +: 16] = 16'(16'h0010 * i);
      bl[16*i +: 16]            = 16'(16'h0010 * i);
      el[16*i +: 16]            = 16'(16'h0100 * (i + 1) + 16'h0020 * i);
    end
    out_ready = 1'b0;
    send({16'h0100, 16'h0100}, wl, bl, el, 1'b1, t0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      x = {16'h0100, 16'h0100}; w = fill_w(16'h0100, 16'h0100); b = rep_b(16'h0000);
      in_valid = 1'b1;
      check("bp_out_valid", {95'd0, out_valid}, 96'd1);
      check("bp_y_hold", y, el);
      check("bp_in_ready", {95'd0, in_ready}, 96'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", {95'd0, in_ready}, 96'd1);
    check("bp_release_out_valid", {95'd0, out_valid}, 96'd0);
    wait_done();

    // reset during MAC
    send({16'h0200, 16'h0100}, fill_w(16'h0080, 16'h0100), rep_b(16'h0040), rep_y(16'h02C0), 1'b1, t0);
    #3 reset = 1'b0;
    #1;
    check("midrst_out_valid", {95'd0, out_valid}, 96'd0);
    check("midrst_y", y, 96'd0);
    exp_q.delete();
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", {95'd0, in_ready}, 96'd1);
    for (int k = 0; k < 6; k++) begin
      check("midrst_no_out", {95'd0, out_valid}, 96'd0);
      @(posedge clk); #1;
    end

    // back-to-back
    send({16'h0000, 16'h0100}, fill_w(16'h0300, 16'h0000), rep_b(16'h0000), rep_y(16'h0300), 1'b0, t0);
    send({16'h0100, 16'h0200}, fill_w(16'hFF00, 16'h0080), rep_b(16'h0200), rep_y(16'h0080), 1'b0, t1);
    send({16'h0080, 16'h0080}, fill_w(16'h0100, 16'h0100), rep_b(16'h0000), rep_y(16'h0100), 1'b1, t2);
    check("b2b_spacing_1", 96'((t1 - t0) / 10), 96'd4);
    check("b2b_spacing_2", 96'((t2 - t1) / 10), 96'd4);
    wait_done();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
